// File: rtl/game_pkg.sv
// Shared definitions for the grid game: board geometry, start positions,
// turn-controller state encoding and result codes.
package game_pkg;

    localparam int GRID_MAX = 11;
    localparam int P0_START_X = 3;
    localparam int P0_START_Y = 3;
    localparam int P1_START_X = 9;
    localparam int P1_START_Y = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_APPLY  = 3'd2,
        ST_REJECT = 3'd3,
        ST_SETTLE = 3'd4,
        ST_OVER   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P0   = 2'b01,
        WIN_P1   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_e;

    // Magnitude of a 5-bit two's complement value; -16 maps to 16 so it
    // can never pass a magnitude limit below 16.
    function automatic logic [5:0] abs5(input logic signed [4:0] v);
        logic signed [5:0] w;
        w = {v[4], v};
        return w[5] ? 6'(-w) : 6'(w);
    endfunction

endpackage

// File: rtl/move_check.sv
// Combinational legality check for one requested move: both axis
// magnitudes within MAX_MAG and not the null move.
module move_check
    import game_pkg::*;
#(
    parameter int MAX_MAG = 3
) (
    input  logic [4:0] x_i,
    input  logic [4:0] y_i,
    output logic       legal_o
);

    logic [5:0] ax;
    logic [5:0] ay;
    logic       in_range;
    logic       is_null;

    assign ax       = abs5(x_i);
    assign ay       = abs5(y_i);
    assign in_range = (ax <= 6'(MAX_MAG)) && (ay <= 6'(MAX_MAG));
    assign is_null  = (x_i == 5'd0) && (y_i == 5'd0);
    assign legal_o  = in_range && !is_null;

endmodule

// File: rtl/turn_controller.sv
// Two-player turn scheduler: validates moves, drives the shared move bus
// and point enables, alternates turns and latches capture/draw results.
module turn_controller
    import game_pkg::*;
#(
    parameter int MAX_TURNS = 20,
    parameter int MAX_MAG   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] move_valid,
    input  logic [4:0] x_req0,
    input  logic [4:0] y_req0,
    input  logic [4:0] x_req1,
    input  logic [4:0] y_req1,
    input  logic [4:0] x0,
    input  logic [4:0] y0,
    input  logic [4:0] x1,
    input  logic [4:0] y1,
    output logic [4:0] mv_x,
    output logic [4:0] mv_y,
    output logic       en0,
    output logic       en1,
    output logic [1:0] move_ack,
    output logic       move_err,
    output logic       turn,
    output logic [5:0] turn_count,
    output logic       game_over,
    output logic [1:0] winner
);

    state_e     state_q, state_d;
    logic [4:0] mv_x_q, mv_x_d;
    logic [4:0] mv_y_q, mv_y_d;
    logic       en0_q, en0_d;
    logic       en1_q, en1_d;
    logic [1:0] ack_q, ack_d;
    logic       err_q, err_d;
    logic       turn_q, turn_d;
    logic [5:0] cnt_q, cnt_d;
    logic       over_q, over_d;
    winner_e    win_q, win_d;

    logic [4:0] req_x;
    logic [4:0] req_y;
    logic       req_vld;
    logic       req_legal;
    logic       capture;
    logic [5:0] cnt_inc;

    // Only the player whose turn it is gets looked at; the other request is ignored.
    assign req_x   = turn_q ? x_req1 : x_req0;
    assign req_y   = turn_q ? y_req1 : y_req0;
    assign req_vld = turn_q ? move_valid[1] : move_valid[0];

    move_check #(
        .MAX_MAG (MAX_MAG)
    ) u_move_check (
        .x_i     (req_x),
        .y_i     (req_y),
        .legal_o (req_legal)
    );

    assign capture = (x0 == x1) && (y0 == y1);
    assign cnt_inc = cnt_q + 6'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mv_x_q  <= '0;
            mv_y_q  <= '0;
            en0_q   <= 1'b0;
            en1_q   <= 1'b0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            turn_q  <= 1'b0;
            cnt_q   <= '0;
            over_q  <= 1'b0;
            win_q   <= WIN_NONE;
        end else begin
            state_q <= state_d;
            mv_x_q  <= mv_x_d;
            mv_y_q  <= mv_y_d;
            en0_q   <= en0_d;
            en1_q   <= en1_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            turn_q  <= turn_d;
            cnt_q   <= cnt_d;
            over_q  <= over_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mv_x_d  = mv_x_q;
        mv_y_d  = mv_y_q;
        en0_d   = 1'b0;
        en1_d   = 1'b0;
        ack_d   = '0;
        err_d   = 1'b0;
        turn_d  = turn_q;
        cnt_d   = cnt_q;
        over_d  = over_q;
        win_d   = win_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    turn_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            // Enable and ack are registered here so they are high for the
            // whole APPLY/REJECT cycle that follows.
            ST_WAIT: begin
                if (req_vld) begin
                    ack_d = turn_q ? 2'b10 : 2'b01;
                    if (req_legal) begin
                        state_d = ST_APPLY;
                        mv_x_d  = req_x;
                        mv_y_d  = req_y;
                        en0_d   = ~turn_q;
                        en1_d   = turn_q;
                    end else begin
                        state_d = ST_REJECT;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_APPLY: begin
                state_d = ST_SETTLE;
            end
            ST_REJECT: begin
                state_d = ST_WAIT;
            end
            ST_SETTLE: begin
                cnt_d = cnt_inc;
                if (capture) begin
                    win_d   = turn_q ? WIN_P1 : WIN_P0;
                    over_d  = 1'b1;
                    state_d = ST_OVER;
                end else if (cnt_inc == 6'(MAX_TURNS)) begin
                    win_d   = WIN_DRAW;
                    over_d  = 1'b1;
                    state_d = ST_OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = ST_WAIT;
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mv_x       = mv_x_q;
    assign mv_y       = mv_y_q;
    assign en0        = en0_q;
    assign en1        = en1_q;
    assign move_ack   = ack_q;
    assign move_err   = err_q;
    assign turn       = turn_q;
    assign turn_count = cnt_q;
    assign game_over  = over_q;
    assign winner     = win_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller with a behavioural model of the two
// point instances (clamped to the 0..11 grid, reset to (3,3) and (9,9)).
module tb_turn_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] move_valid;
    logic [4:0] x_req0, y_req0, x_req1, y_req1;
    logic [4:0] x0, y0, x1, y1;
    logic [4:0] mv_x, mv_y;
    logic       en0, en1;
    logic [1:0] move_ack;
    logic       move_err;
    logic       turn;
    logic [5:0] turn_count;
    logic       game_over;
    logic [1:0] winner;

    int errors = 0;
    int checks = 0;

    turn_controller #(
        .MAX_TURNS (4),
        .MAX_MAG   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .move_valid (move_valid),
        .x_req0     (x_req0),
        .y_req0     (y_req0),
        .x_req1     (x_req1),
        .y_req1     (y_req1),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .mv_x       (mv_x),
        .mv_y       (mv_y),
        .en0        (en0),
        .en1        (en1),
        .move_ack   (move_ack),
        .move_err   (move_err),
        .turn       (turn),
        .turn_count (turn_count),
        .game_over  (game_over),
        .winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] step_pos(input logic [4:0] p, input logic [4:0] d);
        int s;
        s = int'(p) + int'($signed(d));
        if (s < 0) s = 0;
        if (s > 11) s = 11;
        return 5'(s);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x0 <= 5'd3;
            y0 <= 5'd3;
            x1 <= 5'd9;
            y1 <= 5'd9;
        end else begin
            if (en0) begin
                x0 <= step_pos(x0, mv_x);
                y0 <= step_pos(y0, mv_y);
            end
            if (en1) begin
                x1 <= step_pos(x1, mv_x);
                y1 <= step_pos(y1, mv_y);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_game();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Accepted move: request, ack cycle, then SETTLE; returns in WAIT or OVER.
    task automatic play(input logic p, input logic [4:0] dx, input logic [4:0] dy);
        if (p) begin
            x_req1 = dx; y_req1 = dy; move_valid = 2'b10;
        end else begin
            x_req0 = dx; y_req0 = dy; move_valid = 2'b01;
        end
        tick();
        move_valid = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        move_valid = 2'b00;
        x_req0 = '0; y_req0 = '0; x_req1 = '0; y_req1 = '0;
        #12;
        check("rst_en0", 32'(en0), 0);
        check("rst_en1", 32'(en1), 0);
        check("rst_ack", 32'(move_ack), 0);
        check("rst_err", 32'(move_err), 0);
        check("rst_turn", 32'(turn), 0);
        check("rst_cnt", 32'(turn_count), 0);
        check("rst_over", 32'(game_over), 0);
        check("rst_win", 32'(winner), 0);
        check("rst_mv", 32'({mv_x, mv_y}), 0);

        // Basic accepted move by P0
        new_game();
        x_req0 = 5'd2; y_req0 = 5'd1; move_valid = 2'b01;
        tick();
        check("t1_en0", 32'(en0), 1);
        check("t1_en1", 32'(en1), 0);
        check("t1_mvx", 32'(mv_x), 2);
        check("t1_mvy", 32'(mv_y), 1);
        check("t1_ack", 32'(move_ack), 32'b01);
        check("t1_err", 32'(move_err), 0);
        move_valid = 2'b00;
        tick();
        check("t1_en0_off", 32'(en0), 0);
        check("t1_ack_off", 32'(move_ack), 0);
        check("t1_turn_mid", 32'(turn), 0);
        tick();
        check("t1_turn", 32'(turn), 1);
        check("t1_cnt", 32'(turn_count), 1);
        check("t1_pos", 32'({x0, y0}), 32'({5'd5, 5'd4}));

        // Out-of-turn request ignored; simultaneous requests serve current player
        new_game();
        x_req1 = 5'h1F; y_req1 = 5'h1F; move_valid = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_noack", 32'(move_ack), 0);
            check("t2_noen", 32'({en0, en1}), 0);
        end
        x_req0 = 5'd1; y_req0 = 5'd0; move_valid = 2'b11;
        tick();
        check("t2_ack", 32'(move_ack), 32'b01);
        check("t2_en", 32'({en0, en1}), 32'b10);
        check("t2_mv", 32'({mv_x, mv_y}), 32'({5'd1, 5'd0}));
        move_valid = 2'b00;
        tick();
        tick();
        check("t2_pos1", 32'({x1, y1}), 32'({5'd9, 5'd9}));

        // Illegal moves: magnitude 4, then null move
        new_game();
        x_req0 = 5'd4; y_req0 = 5'd0; move_valid = 2'b01;
        tick();
        check("t3a_ack", 32'(move_ack), 32'b01);
        check("t3a_err", 32'(move_err), 1);
        check("t3a_en", 32'({en0, en1}), 0);
        move_valid = 2'b00;
        tick();
        check("t3a_clear", 32'({move_ack, move_err}), 0);
        x_req0 = 5'd0; y_req0 = 5'd0; move_valid = 2'b01;
        tick();
        check("t3b_ack", 32'(move_ack), 32'b01);
        check("t3b_err", 32'(move_err), 1);
        check("t3b_en", 32'({en0, en1}), 0);
        move_valid = 2'b00;
        tick();
        check("t3_turn", 32'(turn), 0);
        check("t3_cnt", 32'(turn_count), 0);
        x_req0 = 5'h10; y_req0 = 5'd0; move_valid = 2'b01;
        tick();
        check("t3c_err_m16", 32'(move_err), 1);
        move_valid = 2'b00;
        tick();
        x_req0 = 5'h1D; y_req0 = 5'd3; move_valid = 2'b01;
        tick();
        check("t3d_edge_legal", 32'({en0, move_err}), 32'b10);
        move_valid = 2'b00;
        tick();
        tick();
        check("t3d_pos", 32'({x0, y0}), 32'({5'd0, 5'd6}));

        // Capture by P1
        new_game();
        play(1'b0, 5'd3, 5'd3);
        check("t4_over_mid", 32'(game_over), 0);
        check("t4_turn_mid", 32'(turn), 1);
        play(1'b1, 5'h1D, 5'h1D);
        check("t4_over", 32'(game_over), 1);
        check("t4_win", 32'(winner), 32'b10);
        check("t4_cnt", 32'(turn_count), 2);
        start = 1'b1;
        x_req0 = 5'd1; y_req0 = 5'd1; x_req1 = 5'd1; y_req1 = 5'd1;
        move_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_dead", 32'({en0, en1, move_ack}), 0);
        end
        start = 1'b0;
        move_valid = 2'b00;
        check("t4_hold", 32'({game_over, winner, turn_count}), 32'({1'b1, 2'b10, 6'd2}));

        // Draw at MAX_TURNS=4
        new_game();
        play(1'b0, 5'd1, 5'd1);
        play(1'b1, 5'h1F, 5'd0);
        play(1'b0, 5'd1, 5'd0);
        check("t5_cnt3", 32'(turn_count), 3);
        check("t5_over3", 32'(game_over), 0);
        check("t5_turn3", 32'(turn), 1);
        x_req1 = 5'd0; y_req1 = 5'h1F; move_valid = 2'b10;
        tick();
        move_valid = 2'b00;
        tick();
        check("t5_pre_settle", 32'({game_over, winner}), 0);
        tick();
        check("t5_win", 32'(winner), 32'b11);
        check("t5_over", 32'(game_over), 1);
        check("t5_cnt", 32'(turn_count), 4);

        // Async reset during APPLY of P1's move
        new_game();
        play(1'b0, 5'd1, 5'd1);
        x_req1 = 5'h1F; y_req1 = 5'h1F; move_valid = 2'b10;
        tick();
        check("t6_en1_pre", 32'(en1), 1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_en", 32'({en0, en1}), 0);
        check("t6_ack", 32'(move_ack), 0);
        check("t6_turn", 32'(turn), 0);
        check("t6_cnt", 32'(turn_count), 0);
        check("t6_win", 32'(winner), 0);
        check("t6_p0", 32'({x0, y0}), 32'({5'd3, 5'd3}));
        check("t6_p1", 32'({x1, y1}), 32'({5'd9, 5'd9}));
        move_valid = 2'b00;
        tick();
        check("t6_held", 32'({en0, en1, turn_count}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
